// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: round-robin owner of the shared TX byte path, holds grant per frame and enforces the IFG.
// Optional stall watchdog compiled in with ETH_TX_TIMEOUT_EN.
module eth_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int IFG_CYCLES     = 48,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] src_data,
  input  logic [NUM_REQ-1:0]   src_valid,
  input  logic [NUM_REQ-1:0]   src_last,
  output logic [NUM_REQ-1:0]   src_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 tx_last,
  input  logic                 tx_ready,
  output logic                 tx_abort,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;
  if (NUM_REQ < 2 || NUM_REQ > 8) $error("NUM_REQ out of range");
  if (IFG_CYCLES < 1 || IFG_CYCLES > 255) $error("IFG_CYCLES out of range");
  if (TIMEOUT_CYCLES < 2) $error("TIMEOUT_CYCLES out of range");
  state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;
  logic xfer;
  always_comb begin
    tx_data  = '0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        tx_data  = src_data[8*i +: 8];
        tx_valid = src_valid[i];
        tx_last  = src_last[i];
      end
    end
  end
  assign src_ready = grant_q & {NUM_REQ{tx_ready}};
  assign xfer      = tx_valid & tx_ready;
  assign grant     = grant_q;
  assign busy      = state_q != IDLE;
`ifdef ETH_TX_TIMEOUT_EN
  localparam int SW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [SW-1:0] stall_cnt_q, stall_cnt_d;
  assign tx_abort    = state_q == STREAM && !xfer && stall_cnt_q == SW'(TIMEOUT_CYCLES - 1);
  assign stall_cnt_d = (state_q != STREAM || xfer) ? '0 : stall_cnt_q + SW'(1);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
`else
  assign tx_abort = 1'b0;
`endif
  always_comb begin
    int idx;
    logic found;
    idx       = 0;
    found     = 1'b0;
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    gap_cnt_d = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        // circular search beginning just after the last winner
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = (int'(rr_ptr_q) + k) % NUM_REQ;
          if (!found && req[idx]) begin
            found        = 1'b1;
            grant_d      = '0;
            grant_d[idx] = 1'b1;
            rr_ptr_d     = IW'(idx);
            state_d      = STREAM;
          end
        end
      end
      STREAM: begin
        if ((xfer && tx_last) || tx_abort) begin
          grant_d   = '0;
          gap_cnt_d = 8'(IFG_CYCLES - 1);
          state_d   = GAP;
        end
      end
      GAP: begin
        state_d   = gap_cnt_q == 8'd0 ? IDLE : GAP;
        gap_cnt_d = gap_cnt_q == 8'd0 ? gap_cnt_q : gap_cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= IW'(NUM_REQ - 1);
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter: directed checks of grant order, IFG timing, stalls and async reset.
module tb_eth_tx_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [1:0] req = '0;
  logic [15:0] src_data = '0;
  logic [1:0] src_valid = '0;
  logic [1:0] src_last = '0;
  logic tx_ready = 1'b0;
  logic [1:0] src_ready, grant;
  logic [7:0] tx_data;
  logic tx_valid, tx_last, tx_abort, busy;
  int checks = 0;
  int errors = 0;
  int n;
  eth_tx_arbiter #(.NUM_REQ(2), .IFG_CYCLES(48), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn), .req(req), .src_data(src_data), .src_valid(src_valid),
    .src_last(src_last), .src_ready(src_ready), .grant(grant), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready), .tx_abort(tx_abort), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic xfer(input int s, input logic [7:0] d, input logic last, input logic [1:0] req_or);
    logic [1:0] e;
    e = 2'b01 << s;
    src_data[8*s +: 8] = d;
    src_valid[s] = 1'b1;
    src_last[s] = last;
    tx_ready = 1'b0;
    #1;
    chk("hold_data", tx_data, d);
    chk("hold_ready", src_ready, 2'b00);
    repeat (3) tick();
    tx_ready = 1'b1;
    req = req | req_or;
    #1;
    chk("tx_data", tx_data, d);
    chk("tx_valid", tx_valid, 1'b1);
    chk("tx_last", tx_last, last);
    chk("src_ready", src_ready, e);
    tick();
    src_valid[s] = 1'b0;
    src_last[s] = 1'b0;
    tx_ready = 1'b0;
    #1;
  endtask
  task automatic wait_grant(output int c);
    c = 0;
    while (grant == 2'b00 && c < 300) begin
      tick();
      c++;
    end
  endtask
  task automatic wait_idle(output int c);
    c = 0;
    while (busy && c < 300) begin
      tick();
      c++;
    end
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_abort", tx_abort, 1'b0);
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_ready", src_ready, 2'b00);
    resetn = 1'b1;
    tick();
    // three-byte frame from source 0
    req = 2'b01;
    tick();
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1'b1);
    req = 2'b00;
    xfer(0, 8'hAA, 1'b0, 2'b00);
    xfer(0, 8'hBB, 1'b0, 2'b00);
    xfer(0, 8'hCC, 1'b1, 2'b00);
    chk("t1_grant_clr", grant, 2'b00);
    chk("t1_gap_valid", tx_valid, 1'b0);
    wait_idle(n);
    chk("t1_busy_len", n, 48);
    // both sources requesting continuously
    resetn = 1'b0;
    #1;
    resetn = 1'b1;
    tick();
    req = 2'b11;
    tick();
    for (int f = 0; f < 4; f++) begin
      if (f > 0) begin
        wait_grant(n);
        chk("t2_gap", n, 49);
      end
      chk("t2_order", grant, 2'b01 << (f % 2));
      xfer(f % 2, 8'h10 + 8'(f), 1'b0, 2'b00);
      xfer(f % 2, 8'h20 + 8'(f), 1'b1, 2'b00);
      chk("t2_clr", grant, 2'b00);
    end
    // source 0 stalls mid-frame while source 1 waits
    wait_grant(n);
    chk("t3_gap", n, 49);
    chk("t3_grant", grant, 2'b01);
    xfer(0, 8'h31, 1'b0, 2'b00);
    req = 2'b10;
    src_data[15:8] = 8'h55;
    src_valid[1] = 1'b1;
    src_last[1] = 1'b1;
    tx_ready = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", grant, 2'b01);
      chk("t3_valid", tx_valid, 1'b0);
      chk("t3_last", tx_last, 1'b0);
      chk("t3_ready", src_ready, 2'b01);
      tick();
    end
    src_valid[1] = 1'b0;
    src_last[1] = 1'b0;
    tx_ready = 1'b0;
    xfer(0, 8'h32, 1'b1, 2'b00);
    chk("t3_clr", grant, 2'b00);
    wait_grant(n);
    chk("t3_next_gap", n, 49);
    chk("t3_next", grant, 2'b10);
    req = 2'b00;
    xfer(1, 8'h41, 1'b1, 2'b00);
    chk("t3_single_clr", grant, 2'b00);
    wait_idle(n);
    // request arriving on the last-byte edge is queued behind the gap
    req = 2'b01;
    tick();
    chk("t4_grant", grant, 2'b01);
    req = 2'b00;
    xfer(0, 8'h51, 1'b0, 2'b00);
    xfer(0, 8'h52, 1'b1, 2'b10);
    chk("t4_clr", grant, 2'b00);
    wait_grant(n);
    chk("t4_gap", n, 49);
    chk("t4_next", grant, 2'b10);
    req = 2'b00;
    xfer(1, 8'h61, 1'b1, 2'b00);
    wait_idle(n);
    // asynchronous reset in the middle of a five-byte frame
    req = 2'b01;
    tick();
    chk("t5_grant", grant, 2'b01);
    req = 2'b00;
    xfer(0, 8'h01, 1'b0, 2'b00);
    xfer(0, 8'h02, 1'b0, 2'b00);
    src_data[7:0] = 8'h03;
    src_valid[0] = 1'b1;
    #2;
    chk("t5_pre_valid", tx_valid, 1'b1);
    resetn = 1'b0;
    #1;
    chk("t5_rst_grant", grant, 2'b00);
    chk("t5_rst_valid", tx_valid, 1'b0);
    chk("t5_rst_busy", busy, 1'b0);
    src_valid[0] = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    req = 2'b10;
    tick();
    chk("t5_after", grant, 2'b10);
    req = 2'b00;
    xfer(1, 8'h71, 1'b1, 2'b00);
    wait_idle(n);
    // source 0 stalls after one byte
    req = 2'b01;
    tick();
    chk("t6_grant", grant, 2'b01);
    req = 2'b00;
    xfer(0, 8'h81, 1'b0, 2'b00);
    tx_ready = 1'b1;
    #1;
`ifdef ETH_TX_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      chk("t6_abort", tx_abort, k == 16);
      if (k < 16) tick();
    end
    tick();
    chk("t6_grant_clr", grant, 2'b00);
    chk("t6_busy", busy, 1'b1);
    chk("t6_abort_end", tx_abort, 1'b0);
`else
    repeat (1000) tick();
    chk("t6_hold", grant, 2'b01);
    chk("t6_abort", tx_abort, 1'b0);
    chk("t6_busy", busy, 1'b1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
